// File: rtl/tl_traffic_model.sv
// Closed-loop intersection model for the left-turn traffic light controller:
// four lane queues fed by arrival pulses, drained at a fixed headway under permit.
module tl_traffic_model #(
    parameter int QW      = 4,
    parameter int DEP_CYC = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            arr_a,
    input  logic            arr_al,
    input  logic            arr_b,
    input  logic            arr_bl,
    input  logic [1:0]      La,
    input  logic [1:0]      Lb,
    output logic            Ta,
    output logic            Tal,
    output logic            Tb,
    output logic            Tbl,
    output logic [4*QW-1:0] q_all,
    output logic [15:0]     served,
    output logic [3:0]      drop,
    output logic            conflict
);

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10,
        LEFT   = 2'b11
    } light_t;

    localparam int TW = (DEP_CYC > 1) ? $clog2(DEP_CYC) : 1;
    localparam logic [QW-1:0] QMAX     = '1;
    localparam logic [TW-1:0] TMR_LAST = TW'(DEP_CYC - 1);

    logic [QW-1:0] r_q   [4];
    logic [TW-1:0] r_tmr [4];
    logic [15:0]   r_served;
    logic [3:0]    r_drop;
    logic          r_conflict;
    light_t        r_prevLa;
    light_t        r_prevLb;

    light_t        w_la;
    light_t        w_lb;
    logic [3:0]    w_arr;
    logic [3:0]    w_permit;
    logic [3:0]    w_dep;
    logic [QW-1:0] w_qNext   [4];
    logic [TW-1:0] w_tmrNext [4];
    logic [3:0]    w_dropNext;
    logic [2:0]    w_depCount;
    logic [16:0]   w_servedSum;
    logic [15:0]   w_servedNext;
    logic          w_conflictNow;

    assign w_la     = light_t'(La);
    assign w_lb     = light_t'(Lb);
    assign w_arr    = {arr_bl, arr_b, arr_al, arr_a};
    assign w_permit = {w_lb == LEFT, w_lb == GREEN, w_la == LEFT, w_la == GREEN};

    // Per-lane headway pacing and queue bookkeeping; a departure and an
    // arrival in the same cycle cancel in the queue but still count as served.
    always_comb begin
        w_dropNext = r_drop;
        w_depCount = 3'd0;
        for (int i = 0; i < 4; i++) begin
            w_dep[i]     = 1'b0;
            w_tmrNext[i] = '0;
            w_qNext[i]   = r_q[i];
            if (w_permit[i] && (r_q[i] != '0)) begin
                if (r_tmr[i] == TMR_LAST) begin
                    w_dep[i] = 1'b1;
                end else begin
                    w_tmrNext[i] = r_tmr[i] + 1'b1;
                end
            end
            if (w_arr[i] && !w_dep[i]) begin
                if (r_q[i] != QMAX) begin
                    w_qNext[i] = r_q[i] + 1'b1;
                end else begin
                    w_dropNext[i] = 1'b1;
                end
            end else if (w_dep[i] && !w_arr[i]) begin
                w_qNext[i] = r_q[i] - 1'b1;
            end
            w_depCount = w_depCount + {2'b00, w_dep[i]};
        end
    end

    assign w_servedSum  = {1'b0, r_served} + {14'd0, w_depCount};
    assign w_servedNext = w_servedSum[16] ? 16'hFFFF : w_servedSum[15:0];

    // Both streets open at once, or a moving light cut straight to red.
    always_comb begin
        w_conflictNow = (w_la != RED) && (w_lb != RED);
        if (((r_prevLa == GREEN) || (r_prevLa == LEFT)) && (w_la == RED)) begin
            w_conflictNow = 1'b1;
        end
        if (((r_prevLb == GREEN) || (r_prevLb == LEFT)) && (w_lb == RED)) begin
            w_conflictNow = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                r_q[i]   <= '0;
                r_tmr[i] <= '0;
            end
            r_served   <= 16'd0;
            r_drop     <= 4'd0;
            r_conflict <= 1'b0;
            r_prevLa   <= RED;
            r_prevLb   <= RED;
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_q[i]   <= w_qNext[i];
                r_tmr[i] <= w_tmrNext[i];
            end
            r_served   <= w_servedNext;
            r_drop     <= w_dropNext;
            r_conflict <= r_conflict | w_conflictNow;
            r_prevLa   <= w_la;
            r_prevLb   <= w_lb;
        end
    end

    assign Ta       = (r_q[0] != '0);
    assign Tal      = (r_q[1] != '0);
    assign Tb       = (r_q[2] != '0);
    assign Tbl      = (r_q[3] != '0);
    assign q_all    = {r_q[3], r_q[2], r_q[1], r_q[0]};
    assign served   = r_served;
    assign drop     = r_drop;
    assign conflict = r_conflict;

endmodule
